// File: rtl/knn_seq_ctrl_pkg.sv
// Shared definitions for the KNN sequencer: state encoding, distance width, default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef KNN_DIST_W
`define KNN_DIST_W(dw) (2*(dw)+1)
`endif

package knn_seq_ctrl_pkg;

  // Sequencer states; encodings are visible to software debug, keep them fixed.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DIST   = 3'd2,
    S_INSERT = 3'd3,
    S_DONE   = 3'd4
  } knn_state_t;

  localparam int KNN_K_DEFAULT       = 4;
  localparam int KNN_LABEL_W_DEFAULT = 4;

endpackage

// File: rtl/knn_seq_ctrl_dist.sv
// Registered squared Euclidean distance between two signed points.
// Latency: 1 cycle; d2 updates on the clock edge where en is high, holds otherwise.
// Backpressure: none; the caller decides when to pulse en.
module knn_dist_unit
  import knn_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_x,
  input  logic signed [DATA_W-1:0] a_y,
  input  logic signed [DATA_W-1:0] b_x,
  input  logic signed [DATA_W-1:0] b_y,
  output logic [`KNN_DIST_W(DATA_W)-1:0] d2
);

  localparam int DIST_W = `KNN_DIST_W(DATA_W);

  logic signed [DATA_W:0]   dx, dy;
  logic [DATA_W-1:0]        mag_x, mag_y;
  logic [2*DATA_W-1:0]      mag_x_w, mag_y_w, sq_x, sq_y;
  logic [DIST_W-1:0]        sum;

  // Differences are one bit wider than the inputs, so their magnitudes always fit
  // in DATA_W unsigned bits and each square fits in 2*DATA_W bits.
  always_comb begin
    dx      = {a_x[DATA_W-1], a_x} - {b_x[DATA_W-1], b_x};
    dy      = {a_y[DATA_W-1], a_y} - {b_y[DATA_W-1], b_y};
    mag_x   = dx[DATA_W] ? DATA_W'(-dx) : dx[DATA_W-1:0];
    mag_y   = dy[DATA_W] ? DATA_W'(-dy) : dy[DATA_W-1:0];
    mag_x_w = {{DATA_W{1'b0}}, mag_x};
    mag_y_w = {{DATA_W{1'b0}}, mag_y};
    sq_x    = mag_x_w * mag_x_w;
    sq_y    = mag_y_w * mag_y_w;
    sum     = {1'b0, sq_x} + {1'b0, sq_y};
  end

  // Result register, loaded only when the sequencer asks for a new distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d2 <= '0;
    end else if (en) begin
      d2 <= sum;
    end
  end

endmodule

// File: rtl/knn_seq_ctrl.sv
// KNN search sequencer: fetches n_points training points, keeps the K nearest sorted (optional KNN_VOTE_EN adds a majority vote).
// Latency: 3 cycles per point with zero-wait memory, start-to-done 3*n_points+1 cycles (1 cycle when n_points==0).
// Backpressure: holds mem_valid/mem_addr stable until mem_ready; start is ignored while a search is running.
module knn_seq_ctrl
  import knn_seq_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int N_W     = 8,
  parameter int K       = KNN_K_DEFAULT,
  parameter int LABEL_W = KNN_LABEL_W_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic signed [DATA_W-1:0]            test_x,
  input  logic signed [DATA_W-1:0]            test_y,
  input  logic [N_W-1:0]                      n_points,
  output logic                                mem_valid,
  output logic [N_W-1:0]                      mem_addr,
  input  logic                                mem_ready,
  input  logic signed [DATA_W-1:0]            mem_x,
  input  logic signed [DATA_W-1:0]            mem_y,
  input  logic [LABEL_W-1:0]                  mem_label,
  output logic                                busy,
  output logic                                done,
  output logic [K*`KNN_DIST_W(DATA_W)-1:0]    nb_dist,
  output logic [K*LABEL_W-1:0]                nb_label,
  output logic [K-1:0]                        nb_valid
`ifdef KNN_VOTE_EN
  ,
  output logic [LABEL_W-1:0]                  vote_label,
  output logic                                vote_valid
`endif
);

  localparam int             DIST_W   = `KNN_DIST_W(DATA_W);
  localparam logic [N_W-1:0] ADDR_ONE = N_W'(1);

  knn_state_t state_q, state_d;

  logic accept_start, fetch_hs, dist_en, ins_en, last_pt;

  logic signed [DATA_W-1:0] test_x_q, test_y_q, pt_x_q, pt_y_q;
  logic [N_W-1:0]           n_points_q, addr_q;
  logic [LABEL_W-1:0]       pt_label_q;
  logic [DIST_W-1:0]        d2;

  logic [DIST_W-1:0]  dist_q  [K];
  logic [DIST_W-1:0]  dist_d  [K];
  logic [LABEL_W-1:0] label_q [K];
  logic [LABEL_W-1:0] label_d [K];
  logic [K-1:0]       valid_q, valid_d, qual;

  assign last_pt  = (addr_q == (n_points_q - ADDR_ONE));
  assign mem_addr = addr_q;
  assign nb_valid = valid_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the strobes that steer the datapath and the status outputs.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    fetch_hs     = 1'b0;
    dist_en      = 1'b0;
    ins_en       = 1'b0;
    mem_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = (n_points == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_valid = 1'b1;
        busy      = 1'b1;
        if (mem_ready) begin
          fetch_hs = 1'b1;
          state_d  = S_DIST;
        end
      end
      S_DIST: begin
        busy    = 1'b1;
        dist_en = 1'b1;
        state_d = S_INSERT;
      end
      S_INSERT: begin
        busy    = 1'b1;
        ins_en  = 1'b1;
        state_d = last_pt ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Search context: test point and count latched at start, fetched point held for the distance unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_x_q   <= '0;
      test_y_q   <= '0;
      n_points_q <= '0;
      addr_q     <= '0;
      pt_x_q     <= '0;
      pt_y_q     <= '0;
      pt_label_q <= '0;
    end else begin
      if (accept_start) begin
        test_x_q   <= test_x;
        test_y_q   <= test_y;
        n_points_q <= n_points;
        addr_q     <= '0;
      end
      if (fetch_hs) begin
        pt_x_q     <= mem_x;
        pt_y_q     <= mem_y;
        pt_label_q <= mem_label;
      end
      if (ins_en && !last_pt) begin
        addr_q <= addr_q + ADDR_ONE;
      end
    end
  end

  knn_dist_unit #(
    .DATA_W (DATA_W)
  ) u_dist (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dist_en),
    .a_x   (pt_x_q),
    .a_y   (pt_y_q),
    .b_x   (test_x_q),
    .b_y   (test_y_q),
    .d2    (d2)
  );

  // A slot accepts the new point if it is empty or strictly farther; ties keep the earlier point nearer.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      qual[i] = !valid_q[i] || (d2 < dist_q[i]);
    end
  end

  // Because the list is sorted with occupied slots packed at the bottom, qual is a
  // thermometer: the first qualifying slot takes the new entry, later ones shift up.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < K; i++) begin
      dist_d[i]  = dist_q[i];
      label_d[i] = label_q[i];
    end
    if (accept_start) begin
      valid_d = '0;
      for (int i = 0; i < K; i++) begin
        dist_d[i]  = '0;
        label_d[i] = '0;
      end
    end else if (ins_en) begin
      if (qual[0]) begin
        dist_d[0]  = d2;
        label_d[0] = pt_label_q;
        valid_d[0] = 1'b1;
      end
      for (int j = 1; j < K; j++) begin
        if (qual[j]) begin
          if (!qual[j-1]) begin
            dist_d[j]  = d2;
            label_d[j] = pt_label_q;
            valid_d[j] = 1'b1;
          end else begin
            dist_d[j]  = dist_q[j-1];
            label_d[j] = label_q[j-1];
            valid_d[j] = valid_q[j-1];
          end
        end
      end
    end
  end

  // Neighbour list registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= '0;
        label_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= dist_d[i];
        label_q[i] <= label_d[i];
      end
    end
  end

  // Flatten the list onto the register-map buses, slot 0 in the LSBs.
  for (genvar g = 0; g < K; g++) begin : g_flat
    assign nb_dist[g*DIST_W +: DIST_W]     = dist_q[g];
    assign nb_label[g*LABEL_W +: LABEL_W]  = label_q[g];
  end

`ifdef KNN_VOTE_EN
  localparam int CNT_W = $clog2(K + 1);

  logic [CNT_W-1:0]   vote_cnt [K];
  logic [CNT_W-1:0]   best_cnt;
  logic [LABEL_W-1:0] best_label;

  // Majority over the list as it will look after this edge; scanning from slot 0 with a
  // strict compare lets the nearest slot's label win a tie.
  always_comb begin
    best_cnt   = '0;
    best_label = '0;
    for (int i = 0; i < K; i++) begin
      vote_cnt[i] = '0;
      for (int j = 0; j < K; j++) begin
        if (valid_d[i] && valid_d[j] && (label_d[i] == label_d[j])) begin
          vote_cnt[i] = vote_cnt[i] + CNT_W'(1);
        end
      end
      if (vote_cnt[i] > best_cnt) begin
        best_cnt   = vote_cnt[i];
        best_label = label_d[i];
      end
    end
  end

  // Vote result, captured as the search finishes and cleared when a new one starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_label <= '0;
      vote_valid <= 1'b0;
    end else if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      vote_label <= best_label;
      vote_valid <= |valid_d;
    end else if (accept_start) begin
      vote_label <= '0;
      vote_valid <= 1'b0;
    end
  end
`endif

endmodule
